// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field positions
// and the fetch-unit state encoding.
package cpu_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

  // Instruction layout: opcode[19:16], operand A[15:8], operand B[7:0]
  localparam int OPC_MSB = 19;
  localparam int OPC_LSB = 16;
  localparam int A_MSB   = 15;
  localparam int A_LSB   = 8;
  localparam int B_MSB   = 7;
  localparam int B_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Pipeline IF stage. Presents PC to a combinational instruction memory,
// captures the returned word into the IF/ID register with its PC and a
// valid bit, and handles stall / flush / branch redirect plus start/halt
// sequencing of a program run.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                pulse: begin or restart a run (IDLE/DONE only)
//   stall                hold PC and IF/ID
//   flush                squash the word captured this cycle
//   redirect_en/_pc      taken branch: load PC from redirect_pc
//   imem_addr            address to instruction memory (= PC)
//   imem_instr           word from memory, same cycle
//   if_id_instr/_pc      registered instruction and its PC
//   if_id_valid          IF/ID holds a real instruction
//   busy, done           state decode: RUN, DONE
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W    = 8,
  parameter int                 INSTR_W   = 20,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [ADDR_W-1:0]  LAST_ADDR = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic               busy,
  output logic               done
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
  logic               valid_q, valid_d;

  logic [OPCODE_W-1:0] opcode;
  logic                halt_hit;

  assign opcode = imem_instr[OPC_MSB:OPC_LSB];

  // A flushed HALT is a squashed word and must not end the run.
  assign halt_hit = (pc_q == LAST_ADDR) || ((opcode == OP_HALT) && !flush);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end

      RUN: begin
        if (redirect_en) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = imem_instr;
          ifpc_d  = pc_q;
          valid_d = !flush;
          if (halt_hit) begin
            state_d = DONE;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end

      DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
          valid_d = 1'b0;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        pc_d    = RESET_PC;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Pipeline IF stage that initiates reads on the instruction-memory interface.
- It drives an 8-bit address to the combinational instruction memory, samples the 20-bit word the same cycle, and registers it into the IF/ID pipeline register together with its PC and a valid bit.
- It supports hazard control: stall from the hazard unit, flush, and redirect from a branch resolved in EX.
- It also provides start/halt sequencing for program runs.

Parameters:
- ADDR_W, 8, instruction address width.
- INSTR_W, 20, instruction width: opcode[19:16], operand A[15:8], operand B[7:0].
- RESET_PC, 8'h00, PC value after reset and on restart.
- LAST_ADDR, 8'hFF, last program address; capturing it ends the run.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  single-cycle pulse; begins or restarts a run.
- stall  in  1  hazard-unit stall; hold PC and IF/ID.
- flush  in  1  squash the word captured this cycle.
- redirect_en  in  1  branch taken; load PC from redirect_pc.
- redirect_pc  in  ADDR_W  branch target.
- imem_addr  out  ADDR_W  address to instruction memory; equals PC (combinational).
- imem_instr  in  INSTR_W  word returned by memory, same cycle.
- if_id_instr  out  INSTR_W  registered instruction.
- if_id_pc  out  ADDR_W  PC of if_id_instr.
- if_id_valid  out  1  IF/ID holds a real instruction.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - rst has highest priority and is honoured mid-run.
  - After reset: state=IDLE, pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0, busy=0, done=0, imem_addr=RESET_PC.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - No capture; if_id_valid=0.
  - start=1 -> RUN with pc=RESET_PC.
  - stall, flush and redirect are ignored.
- RUN: evaluate in priority order each cycle.
  1. redirect_en=1 -> pc<=redirect_pc, if_id_valid<=0, if_id_instr and if_id_pc unchanged. Redirect overrides a simultaneous stall or flush.
  2. stall=1 -> pc, if_id_instr, if_id_pc and if_id_valid all hold. A flush arriving with stall is ignored; the hazard unit must reassert it.
  3. Otherwise: if_id_instr<=imem_instr, if_id_pc<=pc, if_id_valid<=~flush, pc<=pc+1.
     - PC arithmetic is modulo 2^ADDR_W, so 8'hFF wraps to 8'h00.
     - If pc==LAST_ADDR, or imem_instr[19:16]==OP_HALT with flush=0, the word is captured (valid unless flushed), pc holds, and next state is DONE.
- Latency: one cycle from imem_addr presentation to if_id_* valid. Sustained throughput is 1 instruction/cycle absent stalls.
- Penalty: redirect costs one bubble cycle.
- DONE:
  - First cycle in DONE: the final captured word stays visible with if_id_valid as captured.
  - On the next edge without stall, if_id_valid<=0.
  - Remaining in DONE, the pipeline drains.
  - start=1 -> RUN with pc<=RESET_PC and if_id_valid<=0.
  - redirect and flush are ignored.
- start while in RUN is ignored.
- Outputs if_id_* are registered; busy and done decode the state register.

Decomposition:
- Shared package cpu_pkg holds:
  - OPCODE_W=4
  - opcode constants: OP_ADD=4'h0, OP_SUB=4'h1, OP_HALT=4'hF
  - field bit positions (OPC_MSB=19, OPC_LSB=16, A_MSB=15, A_LSB=8, B_MSB=7, B_LSB=0)
  - fetch state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
- Single module; no sub-module. The next-PC mux is inline combinational logic.

Test Plan:
- Program the memory with addr0=20'h00503, addr1=20'h00801, addr2=20'h10802; set LAST_ADDR=2; reset, then pulse start -> over three consecutive cycles if_id_{instr,pc,valid} = (00503,0,1), (00801,1,1), (10802,2,1). Then done=1 and busy=0, and one cycle later if_id_valid=0.
- Assert stall for 2 cycles while IF/ID holds (00801,1) -> IF/ID unchanged and imem_addr=2 throughout. After release, the next capture is (10802,2,1).
- With pc=2, assert redirect_en with redirect_pc=8'h00 and stall=1 in the same cycle -> next cycle if_id_valid=0 and imem_addr=0. The following cycle gives (00503,0,1).
- Assert flush while pc=1 -> if_id_valid=0 with if_id_pc=1, then pc=2 and the next capture is valid.
- Put 20'hF0000 at addr1 with LAST_ADDR=255 -> HALT word captured valid at pc 1, then done=1 and imem_addr holds 1. A start pulse restarts from pc 0.
- Assert rst at mid-run cycle 2 -> next cycle: state IDLE, all outputs at reset values, and start is needed to resume.
